// File: rtl/mic_adc_capture_if.sv
// Bus between the microphone ADC capture block and its neighbours.
//
// Signals:
//   enable_in    - high lets the capture block issue sample ticks
//   sdo_in       - serial data from the ADC, MSB first
//   cs_n_out     - ADC chip select, active low
//   sclk_out     - ADC serial clock, idles low
//   x_out        - signed 16-bit sample for the lowpass stage, held between updates
//   ready_out    - one-cycle strobe, x_out was updated this cycle
//   overrun_out  - sticky, a sample tick arrived while a conversion was running
//
// The master modport is the capture block; the slave modport is the
// surrounding system (ADC pins, downstream filter, control).
interface mic_adc_capture_if;
  logic               enable_in;
  logic               sdo_in;
  logic               cs_n_out;
  logic               sclk_out;
  logic signed [15:0] x_out;
  logic               ready_out;
  logic               overrun_out;

  modport master (
    input  enable_in, sdo_in,
    output cs_n_out, sclk_out, x_out, ready_out, overrun_out
  );

  modport slave (
    output enable_in, sdo_in,
    input  cs_n_out, sclk_out, x_out, ready_out, overrun_out
  );
endinterface

// File: rtl/mic_adc_capture.sv
// Microphone ADC capture: paces audio samples from clk_in, runs one serial
// ADC frame per sample (chip select, 16 serial clocks, MSB-first data) and
// presents the 12-bit offset-binary result as a signed 16-bit sample.
//
// Ports:
//   clk_in  - system clock, single clock domain
//   rst_in  - asynchronous, active-low reset
//   bus     - mic_adc_capture_if.master (enable, ADC pins, sample output)
//
// Parameters:
//   SAMPLE_PERIOD - clk_in cycles per audio sample
//   SCLK_DIV      - clk_in cycles per sclk_out half-period (2..64)
//   ADC_BITS      - ADC result width, must be 12
//   PERIOD_CHECK  - 1 enables the SAMPLE_PERIOD legality assertion; only a
//                   test harness that wants to force overruns sets it to 0
//
// Frame timing, tick in cycle T:
//   T+1 .. T+D            SETUP   cs_n low, sclk low
//   T+D+1 .. T+33D        SHIFT   32 sclk half-periods, first one high
//   T+33D+1               SHIFT   trailing low cycle before cs_n rises
//   T+33D+2               CONVERT cs_n high, x_out valid, ready_out high
module mic_adc_capture #(
  parameter int SAMPLE_PERIOD = 2272,
  parameter int SCLK_DIV      = 4,
  parameter int ADC_BITS      = 12,
  parameter int PERIOD_CHECK  = 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  mic_adc_capture_if.master  bus
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DIV_W = $clog2(SCLK_DIV);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    SHIFT   = 2'd2,
    CONVERT = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   tick_cnt_q;
  logic               tick;
  logic [DIV_W-1:0]   div_cnt_q;
  logic [5:0]         half_cnt_q;
  logic               div_done;
  logic               last_half;
  logic               sclk_high;
  logic               capture;
  logic [15:0]        shift_q;
  logic signed [15:0] x_q;
  logic               overrun_q;

  // ---------------------------------------------------------------------
  // Sample tick counter: free-runs 0..SAMPLE_PERIOD-1 while enabled.
  // ---------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop in the
  // block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tick_cnt_q <= '0;
    end else if (!bus.enable_in) begin
      tick_cnt_q <= '0;
    end else if (tick_cnt_q == CNT_W'(SAMPLE_PERIOD - 1)) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + CNT_W'(1);
    end
  end

  assign tick = bus.enable_in && (tick_cnt_q == CNT_W'(SAMPLE_PERIOD - 1));

  // ---------------------------------------------------------------------
  // Serial clock timing: div_cnt paces half-periods, half_cnt counts them.
  // half_cnt = 32 is the single trailing low cycle that closes the frame.
  // ---------------------------------------------------------------------
  assign div_done  = (div_cnt_q == DIV_W'(SCLK_DIV - 1));
  assign last_half = (half_cnt_q == 6'd32);
  // Even half-periods are the high phases; half_cnt[5] masks the tail cycle.
  assign sclk_high = (state_q == SHIFT) && !half_cnt_q[5] && !half_cnt_q[0];
  // First cycle of a high phase is the cycle sclk_out rises.
  assign capture   = sclk_high && (div_cnt_q == '0);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      div_cnt_q  <= '0;
      half_cnt_q <= '0;
    end else begin
      case (state_q)
        SETUP: begin
          div_cnt_q  <= div_done ? '0 : div_cnt_q + DIV_W'(1);
          half_cnt_q <= '0;
        end
        SHIFT: begin
          div_cnt_q <= div_done ? '0 : div_cnt_q + DIV_W'(1);
          if (div_done && !last_half) begin
            half_cnt_q <= half_cnt_q + 6'd1;
          end
        end
        default: begin
          div_cnt_q  <= '0;
          half_cnt_q <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: combinational blocks assign a default to every output first, so
  // no path through the case statement can leave a value held (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick)      state_d = SETUP;
      SETUP:   if (div_done)  state_d = SHIFT;
      SHIFT:   if (last_half) state_d = CONVERT;
      CONVERT:                state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cs_n_out  = 1'b1;
    bus.sclk_out  = 1'b0;
    bus.ready_out = 1'b0;
    case (state_q)
      SETUP:   bus.cs_n_out  = 1'b0;
      SHIFT: begin
        bus.cs_n_out = 1'b0;
        bus.sclk_out = sclk_high;
      end
      CONVERT: bus.ready_out = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Data path: 16-bit capture, offset-binary to two's complement, overrun.
  // ---------------------------------------------------------------------
  // NOTE: the shift register is reset even though every frame refills it,
  // so that an aborted frame can never leak stale bits into a later result.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      shift_q <= '0;
    end else if (capture) begin
      shift_q <= {shift_q[14:0], bus.sdo_in};
    end
  end

  // The four lead-in bits have been shifted into shift_q[15:12] and are
  // ignored; the result lands in x_q as CONVERT begins.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x_q <= '0;
    end else if ((state_q == SHIFT) && last_half) begin
      x_q <= {~shift_q[11], shift_q[10:0], 4'b0000};
    end
  end

  // A tick is only accepted in IDLE; anywhere else it is dropped and noted.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      overrun_q <= 1'b0;
    end else if (tick && (state_q != IDLE)) begin
      overrun_q <= 1'b1;
    end
  end

  assign bus.x_out       = x_q;
  assign bus.overrun_out = overrun_q;

  // ---------------------------------------------------------------------
  // Simulation checks on configuration and strobe behaviour.
  // ---------------------------------------------------------------------
  param_legal: assert property (@(posedge clk_in) disable iff (!rst_in)
    (ADC_BITS == 12) && (SCLK_DIV >= 2) && (SCLK_DIV <= 64));

  generate
    if (PERIOD_CHECK != 0) begin : g_period_check
      period_legal: assert property (@(posedge clk_in) disable iff (!rst_in)
        SAMPLE_PERIOD >= 33 * SCLK_DIV + 3);
    end
  endgenerate

  ready_single: assert property (@(posedge clk_in) disable iff (!rst_in)
    (state_q == CONVERT) |=> (state_q != CONVERT));

endmodule

// File: doc/mic_adc_capture.md
MIC_ADC_CAPTURE -- requirements
Module: mic_adc_capture

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 2272, clk_in cycles per audio sample (44.0 kHz at 100 MHz).
REQ-002 Parameter SCLK_DIV, default 4, clk_in cycles per sclk_out half-period; legal range 2..64.
REQ-003 Parameter ADC_BITS, default 12, ADC result width; fixed at 12 in this revision.
REQ-004 clk_in  input  1  system clock; single clock domain.
REQ-005 rst_in  input  1  asynchronous, active-low reset.
REQ-006 enable_in  input  1  high = generate sample ticks; low = stop issuing new conversions.
REQ-007 sdo_in  input  1  serial data from ADC, MSB first; sampled on clk_in, no internal synchronizer.
REQ-008 cs_n_out  output  1  ADC chip select, active low.
REQ-009 sclk_out  output  1  ADC serial clock, idle low.
REQ-010 x_out  output  16  signed sample for the lowpass stage, held between updates.
REQ-011 ready_out  output  1  one-cycle strobe: x_out updated this cycle.
REQ-012 overrun_out  output  1  sticky flag: a tick arrived while a conversion was in progress.

Function
REQ-013 Tick counter counts 0..SAMPLE_PERIOD-1 while enable_in=1; the tick is the cycle the counter equals SAMPLE_PERIOD-1; wraps to 0 next cycle.
REQ-014 enable_in=0 holds the counter at 0 and suppresses ticks; a conversion in progress runs to completion and still strobes ready_out.
REQ-015 FSM states: IDLE, SETUP, SHIFT, CONVERT.
REQ-016 IDLE: cs_n_out=1, sclk_out=0; on a tick, go to SETUP next cycle.
REQ-017 SETUP: cs_n_out=0, sclk_out=0 for SCLK_DIV cycles, then go to SHIFT.
REQ-018 SHIFT: sclk_out toggles every SCLK_DIV cycles, starting high, for exactly 16 rising edges (32 half-periods), then go to CONVERT with sclk_out=0.
REQ-019 sdo_in is captured in the clk_in cycle of each sclk_out rising edge into a 16-bit shift register, MSB first; the first 4 bits are ADC lead-in and are discarded.
REQ-020 CONVERT (1 cycle): cs_n_out=1; 12-bit offset-binary result d converted to x_out = {~d[11], d[10:0], 4'b0000}; ready_out=1; return to IDLE.
REQ-021 Latency: ready_out asserts exactly 33*SCLK_DIV+2 clk_in cycles after the tick cycle.
REQ-022 ready_out is high only in CONVERT, never two consecutive cycles.
REQ-023 A tick in any state other than IDLE sets overrun_out=1 and is dropped; the conversion in progress is not disturbed.
REQ-024 overrun_out clears only on reset.
REQ-025 SAMPLE_PERIOD < 33*SCLK_DIV+3 is illegal; a simulation-time assertion flags it.
REQ-026 A tick in the same cycle CONVERT completes is dropped and sets overrun_out.

Reset
REQ-027 rst_in=0 asynchronously forces: FSM=IDLE, counter=0, cs_n_out=1, sclk_out=0, x_out=0x0000, ready_out=0, overrun_out=0, shift register=0.
REQ-028 Reset asserted mid-SHIFT aborts the frame immediately: no ready_out, cs_n_out high in the same cycle.
REQ-029 After rst_in rises, the first tick occurs SAMPLE_PERIOD cycles later with enable_in=1.

Verification
REQ-030 ADC model returns 0x800; SCLK_DIV=4 -> x_out=0x0000, ready_out exactly 134 cycles after the tick.
REQ-031 ADC returns 0xFFF, then 0x000 -> x_out=0x7FF0, then 0x8000; one ready_out per SAMPLE_PERIOD; 16 sclk_out rising edges per cs_n_out low window.
REQ-032 enable_in dropped 10 cycles after a tick -> that frame completes with one ready_out, no further cs_n_out activity; re-enable -> next tick SAMPLE_PERIOD cycles later.
REQ-033 Tick forced during SHIFT via test-only small period (assertion disabled) -> overrun_out=1 and stays 1; x_out equals the in-flight frame's value.
REQ-034 rst_in pulsed low during the 8th sclk_out edge -> cs_n_out=1, sclk_out=0, x_out=0 immediately; no ready_out; normal capture resumes after release.
